// File: rtl/video_capture_writer.sv
// Pixel capture writer: samples pixels inside a frame-latched window and writes
// them into a ring of line buffers, with a one-shot read-side start trigger.
//   state      | meaning
//   WAIT_FRAME | idle after reset, nothing written until the first frame start
//   RUN        | capturing; every frame start re-latches the window and re-arms
module video_capture_writer #(
  parameter int DATA_WIDTH   = 24,
  parameter int COUNTER_BITS = 12,
  parameter int ADDR_BITS    = 15,
  parameter int LINE_LENGTH  = 640,
  parameter int BUFFER_LINES = 4,
  parameter int TRIGGER_ADDR = 1280
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [DATA_WIDTH-1:0]   pixel_in,
  input  logic [COUNTER_BITS-1:0] counterX,
  input  logic [COUNTER_BITS-1:0] counterY,
  input  logic [COUNTER_BITS-1:0] h_start,
  input  logic [COUNTER_BITS-1:0] h_end,
  input  logic [COUNTER_BITS-1:0] v_start,
  input  logic [COUNTER_BITS-1:0] v_end,
  input  logic                    skip_en,
  input  logic [COUNTER_BITS-1:0] skip_start,
  input  logic [COUNTER_BITS-1:0] skip_end,
  output logic                    wren,
  output logic [ADDR_BITS-1:0]    wraddr,
  output logic [DATA_WIDTH-1:0]   wrdata,
  output logic                    starttrigger,
  output logic                    line_done,
  output logic [COUNTER_BITS-1:0] line_count
);

  localparam int unsigned LL_U = LINE_LENGTH;
  localparam int unsigned BL_U = BUFFER_LINES;
  localparam logic [ADDR_BITS-1:0] LINE_STEP = ADDR_BITS'(LINE_LENGTH);
  localparam logic [ADDR_BITS-1:0] LAST_BASE = ADDR_BITS'((BUFFER_LINES - 1) * LINE_LENGTH);
  localparam logic [ADDR_BITS-1:0] TRIG_ADDR = ADDR_BITS'(TRIGGER_ADDR);

  typedef enum logic {WAIT_FRAME, RUN} state_t;
  state_t state;

  logic [COUNTER_BITS-1:0] hs_q, he_q, vs_q, ve_q, ss_q, se_q, line_count_e;
  logic                    sk_q, armed, armed_e;
  logic [ADDR_BITS-1:0]    base, base_e, addr;

  // On a frame-start cycle the freshly latched window applies immediately.
  logic frame_start;
  assign frame_start = (counterX == '0) && (counterY == '0);

  logic [COUNTER_BITS-1:0] hs, he, vs, ve, ss, se, x_off;
  logic                    sk;
  assign hs           = frame_start ? h_start    : hs_q;
  assign he           = frame_start ? h_end      : he_q;
  assign vs           = frame_start ? v_start    : vs_q;
  assign ve           = frame_start ? v_end      : ve_q;
  assign ss           = frame_start ? skip_start : ss_q;
  assign se           = frame_start ? skip_end   : se_q;
  assign sk           = frame_start ? skip_en    : sk_q;
  assign base_e       = frame_start ? '0         : base;
  assign line_count_e = frame_start ? '0         : line_count;
  assign armed_e      = frame_start ? 1'b1       : armed;

  logic active, cfg_ok, in_skip, vline, capture, line_end, fire;
  assign active   = frame_start || (state == RUN);
  assign cfg_ok   = (he > hs) && (ve > vs);
  assign in_skip  = sk && (counterY >= ss) && (counterY < se);
  assign vline    = active && cfg_ok && (counterY >= vs) && (counterY < ve) && !in_skip;
  assign x_off    = counterX - hs;
  assign capture  = vline && (counterX >= hs) && (counterX < he) && (32'(x_off) < LL_U);
  assign line_end = vline && (counterX == he);
  assign addr     = base_e + ADDR_BITS'(x_off);
  assign fire     = capture && armed_e && (addr == TRIG_ADDR) && (32'(line_count_e) < BL_U);

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= WAIT_FRAME;
      hs_q         <= '0;
      he_q         <= '0;
      vs_q         <= '0;
      ve_q         <= '0;
      ss_q         <= '0;
      se_q         <= '0;
      sk_q         <= 1'b0;
      armed        <= 1'b0;
      base         <= '0;
      line_count   <= '0;
      wren         <= 1'b0;
      wraddr       <= '0;
      wrdata       <= '0;
      starttrigger <= 1'b0;
      line_done    <= 1'b0;
    end else begin
      wren         <= 1'b0;
      starttrigger <= 1'b0;
      line_done    <= 1'b0;
      armed        <= armed_e;
      base         <= base_e;
      line_count   <= line_count_e;
      if (frame_start) begin
        state <= RUN;
        hs_q  <= h_start;
        he_q  <= h_end;
        vs_q  <= v_start;
        ve_q  <= v_end;
        ss_q  <= skip_start;
        se_q  <= skip_end;
        sk_q  <= skip_en;
      end
      if (capture) begin
        wren   <= 1'b1;
        wraddr <= addr;
        wrdata <= pixel_in;
        if (fire) begin
          starttrigger <= 1'b1;
          armed        <= 1'b0;
        end
      end
      if (line_end) begin
        line_done <= 1'b1;
        if (line_count_e != '1) line_count <= line_count_e + 1'b1;
        base <= (base_e == LAST_BASE) ? '0 : base_e + LINE_STEP;
      end
    end
  end

endmodule

// File: tb/tb_video_capture_writer.sv
// Randomised and directed raster stimulus for video_capture_writer, checked every
// cycle against a frame-level behavioural model plus literal per-frame tallies.
module tb_video_capture_writer;
  localparam int DW = 8, CB = 8, AB = 7, LL = 16, BL = 4, TA = 32;
  localparam int W = 40, H = 24;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] pixel_in = '0;
  logic [CB-1:0] counterX = 8'd5, counterY = 8'd5;
  logic [CB-1:0] h_start = '0, h_end = '0, v_start = '0, v_end = '0;
  logic [CB-1:0] skip_start = '0, skip_end = '0;
  logic          skip_en = 1'b0;
  logic          wren, starttrigger, line_done;
  logic [AB-1:0] wraddr;
  logic [DW-1:0] wrdata;
  logic [CB-1:0] line_count;

  video_capture_writer #(
    .DATA_WIDTH(DW), .COUNTER_BITS(CB), .ADDR_BITS(AB),
    .LINE_LENGTH(LL), .BUFFER_LINES(BL), .TRIGGER_ADDR(TA)
  ) dut (
    .clock(clock), .reset(reset), .pixel_in(pixel_in),
    .counterX(counterX), .counterY(counterY),
    .h_start(h_start), .h_end(h_end), .v_start(v_start), .v_end(v_end),
    .skip_en(skip_en), .skip_start(skip_start), .skip_end(skip_end),
    .wren(wren), .wraddr(wraddr), .wrdata(wrdata),
    .starttrigger(starttrigger), .line_done(line_done), .line_count(line_count)
  );

  always #5 clock = ~clock;

  int n_checks = 0, n_fail = 0;

  // model: frame-latched window, count of lines finished this frame
  bit m_run, m_armed, m_sk;
  int m_lines, m_hs, m_he, m_vs, m_ve, m_ss, m_se;
  bit e_wren, e_trig, e_done;
  int e_addr, e_data, e_lc;

  int t_writes, t_dones, t_trigs, t_trig_x, t_trig_y, t_done_x, t_post_rst;
  bit t_rst_seen;
  int first_addr[H];
  int first_x[H];

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_step(int x, int y, bit rst, int pix);
    bit vl;
    int addr;
    if (rst) begin
      m_run = 0; m_armed = 0; m_lines = 0;
      e_wren = 0; e_addr = 0; e_data = 0; e_trig = 0; e_done = 0; e_lc = 0;
      return;
    end
    e_wren = 0; e_trig = 0; e_done = 0;
    if (x == 0 && y == 0) begin
      m_run = 1; m_armed = 1; m_lines = 0;
      m_hs = h_start; m_he = h_end; m_vs = v_start; m_ve = v_end;
      m_sk = skip_en; m_ss = skip_start; m_se = skip_end;
    end
    if (m_run && m_he > m_hs && m_ve > m_vs) begin
      vl = (y >= m_vs) && (y < m_ve) && !(m_sk && y >= m_ss && y < m_se);
      if (vl && x >= m_hs && x < m_he && x - m_hs < LL) begin
        addr   = (m_lines % BL) * LL + (x - m_hs);
        e_wren = 1; e_addr = addr; e_data = pix;
        if (addr == TA && m_lines < BL && m_armed) begin
          e_trig = 1; m_armed = 0;
        end
      end
      if (vl && x == m_he) begin
        e_done = 1; m_lines++;
      end
    end
    e_lc = (m_lines > 255) ? 255 : m_lines;
  endtask

  task automatic step(int x, int y);
    counterX = CB'(x);
    counterY = CB'(y);
    pixel_in = DW'($urandom);
    model_step(x, y, reset, int'(pixel_in));
    @(posedge clock);
    #1;
    check("wren", int'(wren), int'(e_wren));
    check("wraddr", int'(wraddr), e_addr);
    check("wrdata", int'(wrdata), e_data);
    check("starttrigger", int'(starttrigger), int'(e_trig));
    check("line_done", int'(line_done), int'(e_done));
    check("line_count", int'(line_count), e_lc);
    if (wren) begin
      t_writes++;
      if (first_addr[y] < 0) begin
        first_addr[y] = int'(wraddr);
        first_x[y]    = x;
      end
      if (t_rst_seen) t_post_rst++;
    end
    if (line_done) begin t_dones++; t_done_x = x; end
    if (starttrigger) begin t_trigs++; t_trig_x = x; t_trig_y = y; end
  endtask

  task automatic set_cfg(int hs, int he, int vs, int ve, bit sk, int ss, int se);
    h_start = CB'(hs); h_end = CB'(he); v_start = CB'(vs); v_end = CB'(ve);
    skip_en = sk; skip_start = CB'(ss); skip_end = CB'(se);
  endtask

  task automatic random_cfg();
    int hs, vs;
    hs = $urandom_range(0, 8);
    vs = $urandom_range(0, 6);
    if ($urandom_range(0, 7) != 0)
      set_cfg(hs, hs + 1 + $urandom_range(0, 30), vs, vs + 1 + $urandom_range(0, 17),
              1'($urandom_range(0, 1)), $urandom_range(0, 12), $urandom_range(0, 20));
    else
      set_cfg(hs, $urandom_range(0, 12), vs, $urandom_range(0, 8), 1'b0, 0, 0);
  endtask

  task automatic frame(int chg_y, int chg_x, bit rnd_chg, int rst_y, int rst_x);
    t_writes = 0; t_dones = 0; t_trigs = 0; t_trig_x = -1; t_trig_y = -1;
    t_done_x = -1; t_post_rst = 0; t_rst_seen = 0;
    for (int i = 0; i < H; i++) begin first_addr[i] = -1; first_x[i] = -1; end
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        if (y == chg_y && x == chg_x) begin
          if (rnd_chg) random_cfg();
          else h_start = 8'd5;
        end
        reset = (y == rst_y && x == rst_x);
        if (reset) t_rst_seen = 1;
        step(x, y);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 3; i++) step(5, 5);
    reset = 1'b0;
    step(5, 5);

    // plain window, ring of four lines, trigger on line 2
    set_cfg(2, 22, 0, 8, 1'b0, 0, 0);
    frame(-1, -1, 0, -1, -1);
    check("f1_writes", t_writes, 128);
    check("f1_dones", t_dones, 8);
    check("f1_line_count", int'(line_count), 8);
    check("f1_trig_count", t_trigs, 1);
    check("f1_trig_x", t_trig_x, 2);
    check("f1_trig_y", t_trig_y, 2);
    check("f1_addr_y1", first_addr[1], 16);
    check("f1_addr_y3", first_addr[3], 48);
    check("f1_addr_y4_wrap", first_addr[4], 0);
    check("f1_addr_y6", first_addr[6], 32);

    // skip band: lines 4..5 dropped without advancing base
    set_cfg(1, 17, 0, 12, 1'b1, 4, 6);
    frame(-1, -1, 0, -1, -1);
    check("skip_writes", t_writes, 160);
    check("skip_dones", t_dones, 10);
    check("skip_line_count", int'(line_count), 10);
    check("skip_addr_y4", first_addr[4], -1);
    check("skip_addr_y3", first_addr[3], 48);
    check("skip_addr_y6", first_addr[6], 0);
    check("skip_x_y6", first_x[6], 1);

    // h_end beyond one line of buffer
    set_cfg(2, 30, 0, 4, 1'b0, 0, 0);
    frame(-1, -1, 0, -1, -1);
    check("wide_writes", t_writes, 64);
    check("wide_done_x", t_done_x, 30);
    check("wide_first_x", first_x[0], 2);

    // mid-frame h_start change only lands at the next frame
    set_cfg(2, 22, 0, 8, 1'b0, 0, 0);
    frame(3, 20, 0, -1, -1);
    check("chg_writes", t_writes, 128);
    check("chg_x_y7", first_x[7], 2);
    frame(-1, -1, 0, -1, -1);
    check("chg_next_x", first_x[0], 5);
    check("chg_next_addr", first_addr[0], 0);
    check("chg_next_writes", t_writes, 128);

    // invalid config
    set_cfg(2, 22, 5, 5, 1'b0, 0, 0);
    frame(-1, -1, 0, -1, -1);
    check("inv_writes", t_writes, 0);
    check("inv_dones", t_dones, 0);
    check("inv_trigs", t_trigs, 0);

    // reset mid-line
    set_cfg(2, 22, 0, 8, 1'b0, 0, 0);
    frame(-1, -1, 0, 3, 10);
    check("rst_post_writes", t_post_rst, 0);
    check("rst_line_count", int'(line_count), 0);
    frame(-1, -1, 0, -1, -1);
    check("rst_next_addr", first_addr[0], 0);
    check("rst_next_writes", t_writes, 128);

    // randomised frames with mid-frame config churn and occasional reset
    for (int f = 0; f < 12; f++) begin
      random_cfg();
      frame($urandom_range(0, H - 1), $urandom_range(0, W - 1), 1,
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, H - 1)) : -1,
            $urandom_range(0, W - 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/video_capture_writer.md
# video_capture_writer

Parametrised pixel-capture writer that sits between the video timing and sync stage and the line-buffer RAM. It samples pixel data inside a programmable capture window and writes it into a ring of line buffers. The window has an optional vertical skip band for line-doubled sources. The block raises a one-shot start trigger for the read side and reports line and frame progress. Window configuration is latched at frame start so it never changes mid-frame.

## Interface
Parameters:
- DATA_WIDTH, 24: pixel word width.
- COUNTER_BITS, 12: width of counterX/counterY and of all window inputs.
- ADDR_BITS, 15: RAM write-address width.
- LINE_LENGTH, 640: RAM words per buffered line and maximum pixels captured per line.
- BUFFER_LINES, 4: number of lines in the ring. LINE_LENGTH*BUFFER_LINES must be ≤ 2^ADDR_BITS.
- TRIGGER_ADDR, 1280: RAM address whose write in the first ring lap fires starttrigger.

Ports:
- clock  in  1  pixel clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high.
- pixel_in  in  DATA_WIDTH  pixel data aligned with the counters.
- counterX, counterY  in  COUNTER_BITS  current raster position.
- h_start, h_end, v_start, v_end  in  COUNTER_BITS  capture window; start is inclusive, end is exclusive.
- skip_en  in  1  enables the vertical skip band.
- skip_start, skip_end  in  COUNTER_BITS  skip band; lines with skip_start ≤ y < skip_end are not captured.
- wren  out  1  RAM write enable.
- wraddr  out  ADDR_BITS  RAM write address.
- wrdata  out  DATA_WIDTH  RAM write data.
- starttrigger  out  1  single-cycle read-side start pulse.
- line_done  out  1  single-cycle pulse after each captured line.
- line_count  out  COUNTER_BITS  number of lines captured in the current frame.

## Operation
- The FSM has two states, WAIT_FRAME and RUN. Reset enters WAIT_FRAME. Frame start is counterX==0 && counterY==0. Frame start moves WAIT_FRAME→RUN; in RUN, a frame start re-arms the frame. The FSM never leaves RUN except on reset.
- At frame start the block latches all window and skip inputs, clears base (line base address) and line_count, and arms the trigger.
- A config is invalid when h_end ≤ h_start or v_end ≤ v_start. An invalid config latched at frame start suppresses all writes, line_done pulses and the trigger for that frame.
- A line is a vertical capture line when v_start ≤ y < v_end, and it is not inside the skip band when skip_en is set.
- A pixel is captured when it is on a vertical capture line and h_start ≤ x < min(h_end, h_start+LINE_LENGTH). All arithmetic is unsigned.
- For a captured pixel: wraddr = base + (x − h_start), wrdata = pixel_in, wren = 1. Otherwise wren = 0; wraddr and wrdata hold their last values.
- Line end is the cycle where counterX equals the latched h_end on a vertical capture line. At line end:
  - line_done pulses.
  - line_count increments and saturates at all-ones.
  - base advances by LINE_LENGTH. It wraps to 0 when base == (BUFFER_LINES−1)*LINE_LENGTH.
- Lines outside the vertical window, or inside the skip band, do not advance base.
- Trigger: starttrigger is asserted together with the write of wraddr == TRIGGER_ADDR, only while line_count < BUFFER_LINES and the trigger is armed. Firing disarms it, so there is at most one pulse per frame.
- Frame start and a capture condition in the same cycle: the latch and clear take effect first, and the pixel is evaluated against the newly latched window.

## Timing
- All outputs are registered. wren, wraddr, wrdata, starttrigger and line_done appear one cycle after the counters that produced them.
- Reset values: wren=0, wraddr=0, wrdata=0, starttrigger=0, line_done=0, line_count=0. Internally: base=0, trigger disarmed, state WAIT_FRAME.
- Reset asserted mid-line stops writes in the next cycle. No writes occur until the next frame start.
- Window input changes mid-frame have no effect until the next frame start.
- Back-to-back lines sustain one write per clock with no bubbles.

## Test plan
- Setup h 44/684, v 0/480, skip off, LINE_LENGTH 640, BUFFER_LINES 4. Drive one frame. Required: 640 writes per line; the first write of each line has wraddr 0, 640, 1280, 1920, then 0 again on line 4; line_count = 480.
- Same setup, TRIGGER_ADDR 1280. Required: exactly one starttrigger, on the write of pixel x=44, y=2. No pulse on the wrap lap (y=6) and none later in the frame.
- Line-doubler setup: h 1/641, v 0/504, skip_en=1 with band 240/263. Required: lines 240–262 produce no writes and no line_done; base continues at line 263 from where line 239 left it; line_count = 481.
- Set h_end=900 with h_start=44. Required: writes cover x = 44..683 only, and line_done fires at x=900.
- Change h_start from 44 to 100 mid-frame. Required: capture stays at 44 for the rest of the frame and starts at 100 in the next frame. An invalid config (v_end=v_start) gives zero writes for that frame.
- Assert reset at x=300 of line 10. Required: wren=0 one cycle later and all outputs at their reset values. No writes occur until the next counterX==0 && counterY==0, after which the first line writes from wraddr 0.
